// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : ctrl_pkg
// Brief  : Shared state encodings, opcode values and one-hot instruction
//          indices for the control sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  // State encoding as seen on the state output
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC1 = 2'd1;
  localparam logic [1:0] ST_EXEC2 = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH = ST_FETCH,
    S_EXEC1 = ST_EXEC1,
    S_EXEC2 = ST_EXEC2,
    S_HALT  = ST_HALT
  } state_t;

  // Opcode values (low nibble of the opcode field)
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JMI = 4'd5;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;

  // Bit positions in the one-hot instruction vector
  localparam int I_LDA   = 0;
  localparam int I_STA   = 1;
  localparam int I_ADD   = 2;
  localparam int I_SUB   = 3;
  localparam int I_JMP   = 4;
  localparam int I_JMI   = 5;
  localparam int I_JEQ   = 6;
  localparam int I_STP   = 7;
  localparam int I_LDI   = 8;
  localparam int I_LSR   = 9;
  localparam int I_ASR   = 10;
  localparam int N_INSTR = 11;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_op_decode.sv
//------------------------------------------------------------------------------
// Module : op_decode
// Brief  : Combinational opcode decoder: opcode field to one-hot instruction
//          vector plus an illegal flag. Any nonzero bit above [3] is illegal.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module op_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]    ir_op,
  output logic [N_INSTR-1:0] instr,
  output logic               illegal
);

  logic upper_zero;

  generate
    if (OP_W > 4) begin : g_upper
      assign upper_zero = ~|ir_op[OP_W-1:4];
    end else begin : g_no_upper
      assign upper_zero = 1'b1;
    end
  endgenerate

  // Decode the low nibble; an unknown code or dirty upper bits yields no instruction
  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (ir_op[3:0])
      OP_LDA:  instr[I_LDA] = 1'b1;
      OP_STA:  instr[I_STA] = 1'b1;
      OP_ADD:  instr[I_ADD] = 1'b1;
      OP_SUB:  instr[I_SUB] = 1'b1;
      OP_JMP:  instr[I_JMP] = 1'b1;
      OP_JMI:  instr[I_JMI] = 1'b1;
      OP_JEQ:  instr[I_JEQ] = 1'b1;
      OP_STP:  instr[I_STP] = 1'b1;
      OP_LDI:  instr[I_LDI] = 1'b1;
      OP_LSR:  instr[I_LSR] = 1'b1;
      OP_ASR:  instr[I_ASR] = 1'b1;
      default: illegal      = 1'b1;
    endcase
    if (!upper_zero) begin
      instr   = '0;
      illegal = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// Module : control_sequencer
// Brief  : FETCH/EXEC1/EXEC2/HALT control FSM with memory-ready handshake,
//          optional fetch overlap in EXEC2, retired-instruction counter and
//          illegal-opcode flag. All strobes are Mealy outputs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int PIPELINE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             acc_eq,
  input  logic             acc_mi,
  input  logic             mem_ready,
  input  logic             resume,
  output logic [1:0]       state,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             wren,
  output logic             addr_sel,
  output logic             acc_src,
  output logic             acc_src_full,
  output logic             pc_sload,
  output logic             pc_cnt_en,
  output logic             acc_en,
  output logic             acc_load,
  output logic             acc_shiftin,
  output logic             addsub,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t               cur_state;
  state_t               nxt_state;
  logic [N_INSTR-1:0]   instr;
  logic                 dec_illegal;
  logic                 retire;
  logic                 mem_op;

  op_decode #(.OP_W(OP_W)) u_op_decode (
    .ir_op   (ir_op),
    .instr   (instr),
    .illegal (dec_illegal)
  );

  // Instructions that read an operand from memory and finish in EXEC2
  assign mem_op = instr[I_LDA] | instr[I_ADD] | instr[I_SUB];

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

  // Next-state and Mealy strobe decode; all strobes are silenced during reset
  always_comb begin
    nxt_state    = cur_state;
    retire       = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    wren         = 1'b0;
    addr_sel     = 1'b0;
    acc_src      = 1'b0;
    acc_src_full = 1'b0;
    pc_sload     = 1'b0;
    pc_cnt_en    = 1'b0;
    acc_en       = 1'b0;
    acc_load     = 1'b0;
    acc_shiftin  = 1'b0;
    addsub       = 1'b0;
    illegal      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_cnt_en = 1'b1;
          nxt_state = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (dec_illegal) begin
          illegal   = 1'b1;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else if (mem_op) begin
          addr_sel = 1'b1;
          if (mem_ready) begin
            mdr_load  = 1'b1;
            nxt_state = S_EXEC2;
          end
        end else if (instr[I_STA]) begin
          // Address and write enable stay stable across the whole wait
          addr_sel = 1'b1;
          wren     = 1'b1;
          if (mem_ready) begin
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end
        end else if (instr[I_STP]) begin
          retire    = 1'b1;
          nxt_state = S_HALT;
        end else begin
          // Single-cycle register-only instructions
          pc_sload     = instr[I_JMP] | (instr[I_JMI] & acc_mi) | (instr[I_JEQ] & acc_eq);
          acc_en       = instr[I_LDI] | instr[I_LSR] | instr[I_ASR];
          acc_load     = instr[I_LDI];
          acc_src      = instr[I_LDI];
          acc_src_full = instr[I_LSR] | instr[I_ASR];
          acc_shiftin  = instr[I_ASR] & acc_mi;
          retire       = 1'b1;
          nxt_state    = S_FETCH;
        end
      end
      S_EXEC2: begin
        // ACC write-back fires once whether or not the overlapped fetch succeeds
        acc_en       = 1'b1;
        acc_load     = 1'b1;
        addsub       = instr[I_ADD];
        acc_src      = instr[I_LDA];
        acc_src_full = instr[I_LDA];
        retire       = 1'b1;
        nxt_state    = S_FETCH;
        if (PIPELINE != 0) begin
          if (mem_ready) begin
            ir_load   = 1'b1;
            pc_cnt_en = 1'b1;
            nxt_state = S_EXEC1;
          end
        end
      end
      S_HALT: begin
        if (resume) nxt_state = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase
    if (reset) begin
      ir_load      = 1'b0;
      mdr_load     = 1'b0;
      wren         = 1'b0;
      addr_sel     = 1'b0;
      acc_src      = 1'b0;
      acc_src_full = 1'b0;
      pc_sload     = 1'b0;
      pc_cnt_en    = 1'b0;
      acc_en       = 1'b0;
      acc_load     = 1'b0;
      acc_shiftin  = 1'b0;
      addsub       = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

`default_nettype wire
